smooth_ctrl: RTL and testbench
==============================

SMOOTH_CTRL -- requirements
Module: smooth_ctrl

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels; SHALL be even and >= 6.
REQ-002 Parameter IMG_H, default 4, image height in rows; SHALL be >= 3.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a frame; acted on only in IDLE.
REQ-006 pix_in  in  8 x [1:0]  two raster-order pixels per beat; element 0 is the even (left) column.
REQ-007 in_valid / in_ready  in / out  1 / 1  input beat handshake; a beat transfers when both are high on a clock edge.
REQ-008 window  out  8 x [8:0][1:0]  registered 3x3 neighbourhoods for two adjacent centre pixels; drives the box-filter datapath image port.
REQ-009 dp_stall  out  1  freeze for the box-filter datapath.
REQ-010 dp_reset  out  1  active-high reset for the datapath, equal to ~reset.
REQ-011 out_valid / out_ready  out / in  1 / 1  marks the datapath output as a valid result; downstream accept.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 frame_done  out  1  one-cycle pulse in DONE.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE->RUN on start; row counter r, pair counter p, and the valid pipeline SHALL clear on entry.
REQ-016 In RUN: in_ready = ~dp_stall. In all other states: in_ready = 0.
REQ-017 Accepted beats SHALL arrive in pair order p = 0..IMG_W/2-1 within each row, and rows in order r = 0..IMG_H-1; p wraps to 0 and r increments on p = IMG_W/2-1.
REQ-018 Two line buffers of IMG_W/2 x 16 bits SHALL hold rows r-1 and r-2, indexed by p; each accepted beat is written at index p and the older row is read out.
REQ-019 Per row, a 3-pair-deep column shift register SHALL hold pairs p-2, p-1 and p.
REQ-020 A window SHALL be issued on an accepted beat only if r >= 2 and p >= 2; it is centred on row r-1 at columns 2(p-1)+i, for i in {0,1}.
REQ-021 Window index j = 3*dr + dc, with dr, dc in 0..2; the pixel is at row (r-2+dr), column (2p-3+i+dc). No border padding: centre columns 0, 1, W-2, W-1 and rows 0, H-1 SHALL produce no output.
REQ-022 Outputs per frame SHALL be (IMG_H-2)*(IMG_W/2-2).
REQ-023 Valid pipeline v0 (window register), v1 (datapath sum stage), v2 (datapath divide stage) SHALL track the datapath's 2-cycle latency.
REQ-024 v0 SHALL load the issue flag on an accepted beat, otherwise 0; v1 <= v0; v2 <= v1. All of v0, v1, v2 and window SHALL advance only when dp_stall = 0.
REQ-025 out_valid = v2.
REQ-026 dp_stall = v2 & ~out_ready (combinational); while high, window, v0..v2 and counters SHALL hold.
REQ-027 The RUN->DRAIN transition SHALL occur on the accepted beat with r = IMG_H-1 and p = IMG_W/2-1.
REQ-028 DRAIN->DONE SHALL occur when v0 = v1 = v2 = 0 (last result consumed); DONE->IDLE after one cycle.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 in_valid outside RUN SHALL be ignored.
REQ-031 A simultaneous start and stall in IDLE SHALL still enter RUN.
REQ-032 in_valid low in RUN SHALL insert bubbles (v0 = 0) without corrupting counters or buffers.

Reset
REQ-033 With reset = 0 at a clock edge, the block SHALL force: state = IDLE; r, p, v0..v2 = 0; window = 0; in_ready, out_valid, busy, frame_done = 0; dp_reset = 1.
REQ-034 Reset mid-frame SHALL abandon the frame.
REQ-035 Line buffer contents need not be cleared.

Verification
REQ-036 W=8, H=4, pixel = 16*row + col, out_ready = 1. Expect 4 results. First window: [0][0]=1, [4][0]=18, [8][0]=35, [0][1]=2, [4][1]=19, [8][1]=36. out_valid 3 cycles after the row-2, pair-2 beat.
REQ-037 Constant image 90, full datapath attached. Expect every result = 90 on both lanes; frame_done exactly once, after the 4th out_valid handshake.
REQ-038 out_ready held low for 5 cycles while out_valid = 1. Expect dp_stall = 1, in_ready = 0, and window/result stable for those 5 cycles; no result lost or duplicated.
REQ-039 in_valid toggled every other cycle. Expect the same 4 results in the same order; bubbles have v0 = 0.
REQ-040 Reset asserted at beat 10, then start. Expect all outputs at their reset values; the next frame yields exactly 4 correct results.
REQ-041 start pulsed during RUN and DRAIN. Expect no effect on counts; busy stays high until DONE.

Source files
------------

// File: rtl/smooth_ctrl.sv
// Control and window formation for a 3x3 box-filter datapath fed two pixels per beat.
// Line buffers hold the two previous rows; per-row pair history plus the live beat forms each window.
module smooth_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0][7:0]      pix_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8:0][1:0][7:0] window,
    output logic                 dp_stall,
    output logic                 dp_reset,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int PAIRS = IMG_W / 2;
    localparam int PW    = $clog2(PAIRS);
    localparam int RW    = $clog2(IMG_H);
    localparam logic [PW-1:0] P_LAST = PW'(PAIRS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [RW-1:0] r;
    logic [PW-1:0] p;
    logic          v0, v1, v2;
    logic          accept, issue;

    logic [15:0]      lb1 [PAIRS];
    logic [15:0]      lb2 [PAIRS];
    logic [1:0][15:0] sr_a, sr_b, sr_c;
    logic [2:0][5:0][7:0] line;
    logic [8:0][1:0][7:0] win_next;

    assign dp_stall   = v2 & ~out_ready;
    assign dp_reset   = ~reset;
    assign out_valid  = v2;
    assign in_ready   = (state == S_RUN) & ~dp_stall;
    assign busy       = (state == S_RUN) | (state == S_DRAIN);
    assign frame_done = (state == S_DONE);
    assign accept     = in_valid & in_ready;
    assign issue      = (r >= RW'(2)) && (p >= PW'(2));

    // Shift registers keep pairs p-1 ([1]) and p-2 ([0]); the live beat supplies pair p,
    // so each line spans columns 2p-4 .. 2p+1 of rows r-2, r-1, r.
    always_comb begin
        line[0] = {lb2[p], sr_a};
        line[1] = {lb1[p], sr_b};
        line[2] = {pix_in, sr_c};
        win_next = '0;
        for (int unsigned dr = 0; dr < 3; dr++) begin
            for (int unsigned dc = 0; dc < 3; dc++) begin
                for (int unsigned i = 0; i < 2; i++) begin
                    win_next[3*dr+dc][i] = line[dr][1+i+dc];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            r      <= '0;
            p      <= '0;
            v0     <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            window <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        r     <= '0;
                        p     <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (p == P_LAST) begin
                            p <= '0;
                            r <= r + 1'b1;
                            if (r == R_LAST) state <= S_DRAIN;
                        end else begin
                            p <= p + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!v0 && !v1 && !v2) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase

            if (state == S_IDLE && start) begin
                v0 <= 1'b0;
                v1 <= 1'b0;
                v2 <= 1'b0;
            end else if (!dp_stall) begin
                v0 <= accept & issue;
                v1 <= v0;
                v2 <= v1;
                if (accept) window <= win_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[p] <= pix_in;
            lb2[p] <= lb1[p];
            sr_a   <= {lb2[p], sr_a[1]};
            sr_b   <= {lb1[p], sr_b[1]};
            sr_c   <= {pix_in, sr_c[1]};
        end
    end
endmodule

// File: tb/tb_smooth_ctrl.sv
// Randomized bench for smooth_ctrl with a behavioural box-filter datapath and an
// image-level reference of every expected window and average.
module tb_smooth_ctrl;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int PAIRS = W / 2;
    localparam int NB    = H * PAIRS;
    localparam int NOUT  = (H - 2) * (PAIRS - 2);
    localparam int LIMIT = 3000;

    typedef logic [8:0][1:0][7:0] win_t;

    logic            clk = 1'b0;
    logic            reset, start, in_valid, out_ready;
    logic [1:0][7:0] pix_in;
    logic            in_ready, dp_stall, dp_reset, out_valid, busy, frame_done;
    win_t            window;

    smooth_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .start(start), .pix_in(pix_in),
        .in_valid(in_valid), .in_ready(in_ready), .window(window),
        .dp_stall(dp_stall), .dp_reset(dp_reset), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Behavioural datapath: sum stage then divide stage, frozen by dp_stall.
    win_t            wp1, wp2;
    logic [1:0][11:0] s1;
    logic [1:0][7:0]  res;

    function automatic logic [11:0] wsum(input win_t w, input int i);
        int s = 0;
        for (int j = 0; j < 9; j++) s += int'(w[j][i]);
        return 12'(s);
    endfunction

    always @(posedge clk) begin
        if (dp_reset) begin
            wp1 <= '0; wp2 <= '0; s1 <= '0; res <= '0;
        end else if (!dp_stall) begin
            wp1    <= window;
            wp2    <= wp1;
            s1[0]  <= wsum(window, 0);
            s1[1]  <= wsum(window, 1);
            res[0] <= 8'(s1[0] / 12'd9);
            res[1] <= 8'(s1[1] / 12'd9);
        end
    end

    int   n_checks = 0, n_pass = 0;
    logic [7:0] img [H][W];
    win_t exp_q [$];
    win_t first_win;
    int   hs, dones, first_ov, beat_c, stall_seen;
    bit   frame_active;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] avg(input win_t w, input int i);
        int s = 0;
        for (int j = 0; j < 9; j++) s += int'(w[j][i]);
        return 8'(s / 9);
    endfunction

    task automatic fill_img(input int mode);
        for (int rr = 0; rr < H; rr++)
            for (int cc = 0; cc < W; cc++)
                img[rr][cc] = (mode == 0) ? 8'(16*rr + cc) : (mode == 1) ? 8'd90 : 8'($urandom_range(0, 255));
    endtask

    // Every interior centre (rows 1..H-2, columns 2..W-3) in raster order.
    task automatic build_exp();
        win_t w;
        exp_q.delete();
        for (int cr = 1; cr <= H - 2; cr++)
            for (int cc = 2; cc <= W - 4; cc += 2) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        for (int i = 0; i < 2; i++)
                            w[3*dr+dc][i] = img[cr-1+dr][cc+i-1+dc];
                exp_q.push_back(w);
            end
    endtask

    task automatic monitor();
        win_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (hs == 0) first_win = wp2;
                if (exp_q.size() == 0) check("extra_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("window", wp2, e);
                    check("res0", res[0], avg(e, 0));
                    check("res1", res[1], avg(e, 1));
                end
                hs++;
            end
            if (frame_done) dones++;
            if (frame_active) begin
                if (out_valid && first_ov < 0) first_ov = cyc_n;
                check("busy", busy, !frame_done);
                if (frame_done) begin
                    check("done_after", hs, NOUT);
                    frame_active = 0;
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_dp_reset"}, dp_reset, 1);
        check({tag, "_dp_stall"}, dp_stall, 0);
        check({tag, "_window"}, window, '0);
    endtask

    task automatic drive_beats(input int vmode, input int abort_at);
        int idx = 0, lc = 0, wt = 0;
        bit acc;
        while (idx < NB && lc < LIMIT) begin
            in_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (lc % 2 == 0) : 1'($urandom_range(0, 1));
            pix_in[0] = img[idx / PAIRS][2 * (idx % PAIRS)];
            pix_in[1] = img[idx / PAIRS][2 * (idx % PAIRS) + 1];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc && idx == 2 * PAIRS + 2) beat_c = cyc_n;
            @(posedge clk); #1;
            lc++;
            if (acc) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                in_valid = 0; reset = 0; frame_active = 0;
                @(posedge clk); #1;
                @(negedge clk);
                check_reset_state("abort");
                @(posedge clk); #1;
                reset = 1;
                return;
            end
        end
        in_valid = 0;
        check("beats_accepted", idx, NB);
        while (frame_active && wt < 200) begin
            @(posedge clk); #1;
            wt++;
        end
        if (frame_active) begin
            check("frame_timeout", 0, 1);
            frame_active = 0;
        end
    endtask

    task automatic drive_ready(input int rmode);
        win_t held;
        stall_seen = 0;
        out_ready = (rmode != 2);
        while (frame_active) begin
            @(negedge clk);
            if (rmode == 2 && stall_seen < 5 && out_valid && !out_ready) begin
                if (stall_seen == 0) held = window;
                else check("stall_window", window, held);
                check("stall_dp", dp_stall, 1);
                check("stall_in_ready", in_ready, 0);
                stall_seen++;
            end
            @(posedge clk); #1;
            case (rmode)
                0:       out_ready = 1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (stall_seen >= 5);
            endcase
        end
        out_ready = 1;
    endtask

    task automatic drive_spur(input bit spur);
        while (frame_active) begin
            @(posedge clk); #1;
            start = frame_active && spur && ($urandom_range(0, 3) == 0);
        end
        start = 0;
    endtask

    task automatic run_frame(input int vmode, input int rmode, input bit spur, input int abort_at);
        build_exp();
        hs = 0; dones = 0; first_ov = -1; beat_c = -1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        frame_active = 1;
        fork
            drive_beats(vmode, abort_at);
            drive_ready(rmode);
            drive_spur(spur);
        join
        repeat (2) @(posedge clk);
        #1;
        if (abort_at < 0) begin
            check("n_results", hs, NOUT);
            check("n_done", dones, 1);
            check("latency", first_ov - beat_c, 3);
            check("queue_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        reset = 0; start = 0; in_valid = 0; pix_in = '0; out_ready = 1; frame_active = 0;
        hs = 0; dones = 0; first_ov = -1; beat_c = -1; stall_seen = 0;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        reset = 1;

        fill_img(0); run_frame(0, 0, 0, -1);
        check("w0_l0", first_win[0][0], 8'd1);
        check("w4_l0", first_win[4][0], 8'd18);
        check("w8_l0", first_win[8][0], 8'd35);
        check("w0_l1", first_win[0][1], 8'd2);
        check("w4_l1", first_win[4][1], 8'd19);
        check("w8_l1", first_win[8][1], 8'd36);

        fill_img(1); run_frame(0, 0, 0, -1);
        fill_img(2); run_frame(0, 2, 0, -1);
        check("stall_cycles", stall_seen, 5);
        fill_img(0); run_frame(1, 0, 0, -1);
        fill_img(2); run_frame(2, 1, 0, 10);
        fill_img(2); run_frame(2, 1, 0, -1);
        fill_img(2); run_frame(2, 1, 1, -1);
        repeat (3) begin
            fill_img(2); run_frame(2, 1, 1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
